// File: rtl/jtag_tap_gen.sv
// rtl/jtag_tap_gen.sv - JTAG TAP with boundary scan, IDCODE and addressed CONFIG data register
`timescale 1ns/1ps

module jtag_tap_gen #(
  parameter int          IR_LEN     = 4,
  parameter int          PINS_IN    = 4,
  parameter int          PINS_OUT   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0CAF,
  parameter int          CFG_W      = 32,
  parameter int          ADDR_W     = 3
) (
  input  logic                tck,
  input  logic                trst,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  input  logic [PINS_IN-1:0]  pins_in,
  output logic [PINS_OUT-1:0] pins_out,
  output logic [PINS_IN-1:0]  logic_pins_in,
  input  logic [PINS_OUT-1:0] logic_pins_out,
  output logic                active,
  output logic [ADDR_W-1:0]   cfg_addr,
  output logic [CFG_W-1:0]    cfg_data,
  output logic                cfg_strobe,
  input  logic [CFG_W-1:0]    cfg_rdata
);

  localparam int BSR_W = PINS_IN + PINS_OUT;
  localparam int CDR_W = CFG_W + ADDR_W;

  localparam logic [IR_LEN-1:0] OP_EXTEST = IR_LEN'(1);
  localparam logic [IR_LEN-1:0] OP_SAMPLE = IR_LEN'(2);
  localparam logic [IR_LEN-1:0] OP_INTEST = IR_LEN'(3);
  localparam logic [IR_LEN-1:0] OP_IDCODE = IR_LEN'(4);
  localparam logic [IR_LEN-1:0] OP_CONFIG = IR_LEN'(5);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;

  tap_state_t state, state_nxt;

  logic in_tlr, capture_ir, shift_ir, update_ir;
  logic capture_dr, shift_dr, update_dr;

  logic [IR_LEN-1:0] ir_sr, ir;
  logic              bypass_sr;
  logic [31:0]       id_sr;
  logic [BSR_W-1:0]  bsr_sr, bsr_upd;
  logic [CDR_W-1:0]  cfg_sr;

  logic is_extest, is_sample, is_intest, is_idcode, is_config;
  logic sel_bsr, dr_tdo;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) state <= TLR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TLR:    state_nxt = tms ? TLR    : RTI;
      RTI:    state_nxt = tms ? SEL_DR : RTI;
      SEL_DR: state_nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_nxt = tms ? EX1_DR : SH_DR;
      SH_DR:  state_nxt = tms ? EX1_DR : SH_DR;
      EX1_DR: state_nxt = tms ? UPD_DR : PAU_DR;
      PAU_DR: state_nxt = tms ? EX2_DR : PAU_DR;
      EX2_DR: state_nxt = tms ? UPD_DR : SH_DR;
      UPD_DR: state_nxt = tms ? SEL_DR : RTI;
      SEL_IR: state_nxt = tms ? TLR    : CAP_IR;
      CAP_IR: state_nxt = tms ? EX1_IR : SH_IR;
      SH_IR:  state_nxt = tms ? EX1_IR : SH_IR;
      EX1_IR: state_nxt = tms ? UPD_IR : PAU_IR;
      PAU_IR: state_nxt = tms ? EX2_IR : PAU_IR;
      EX2_IR: state_nxt = tms ? UPD_IR : SH_IR;
      UPD_IR: state_nxt = tms ? SEL_DR : RTI;
      default: state_nxt = TLR;
    endcase
  end

  always_comb begin
    in_tlr     = 1'b0;
    capture_ir = 1'b0;
    shift_ir   = 1'b0;
    update_ir  = 1'b0;
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
    case (state)
      TLR:    in_tlr     = 1'b1;
      CAP_IR: capture_ir = 1'b1;
      SH_IR:  shift_ir   = 1'b1;
      UPD_IR: update_ir  = 1'b1;
      CAP_DR: capture_dr = 1'b1;
      SH_DR:  shift_dr   = 1'b1;
      UPD_DR: update_dr  = 1'b1;
      default: ;
    endcase
  end

  // Unlisted opcodes (including all-ones) fall through to BYPASS.
  assign is_extest = (ir == OP_EXTEST);
  assign is_sample = (ir == OP_SAMPLE);
  assign is_intest = (ir == OP_INTEST);
  assign is_idcode = (ir == OP_IDCODE);
  assign is_config = (ir == OP_CONFIG);
  assign sel_bsr   = is_extest | is_sample | is_intest;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_sr <= '0;
      ir    <= OP_IDCODE;
    end else if (in_tlr) begin
      ir_sr <= '0;
      ir    <= OP_IDCODE;
    end else begin
      if (capture_ir)    ir_sr <= IR_LEN'(1);
      else if (shift_ir) ir_sr <= {tdi, ir_sr[IR_LEN-1:1]};
      if (update_ir)     ir    <= ir_sr;
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      bypass_sr <= 1'b0;
      id_sr     <= '0;
      bsr_sr    <= '0;
      cfg_sr    <= '0;
    end else if (in_tlr) begin
      bypass_sr <= 1'b0;
      id_sr     <= '0;
      bsr_sr    <= '0;
      cfg_sr    <= '0;
    end else if (capture_dr) begin
      if (is_idcode)                   id_sr <= IDCODE_VAL;
      else if (is_config)              cfg_sr <= {cfg_addr, cfg_rdata};
      else if (is_extest || is_sample) bsr_sr <= {logic_pins_out, pins_in};
      else if (is_intest)              bsr_sr[BSR_W-1:PINS_IN] <= logic_pins_out;
      else                             bypass_sr <= 1'b0;
    end else if (shift_dr) begin
      if (is_idcode)      id_sr     <= {tdi, id_sr[31:1]};
      else if (is_config) cfg_sr    <= {tdi, cfg_sr[CDR_W-1:1]};
      else if (sel_bsr)   bsr_sr    <= {tdi, bsr_sr[BSR_W-1:1]};
      else                bypass_sr <= tdi;
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      bsr_upd    <= '0;
      cfg_addr   <= '0;
      cfg_data   <= '0;
      cfg_strobe <= 1'b0;
    end else if (in_tlr) begin
      bsr_upd    <= '0;
      cfg_addr   <= '0;
      cfg_data   <= '0;
      cfg_strobe <= 1'b0;
    end else begin
      cfg_strobe <= update_dr && is_config;
      if (update_dr && sel_bsr)   bsr_upd <= bsr_sr;
      if (update_dr && is_config) {cfg_addr, cfg_data} <= cfg_sr;
    end
  end

  always_comb begin
    dr_tdo = bypass_sr;
    if (is_idcode)      dr_tdo = id_sr[0];
    else if (is_config) dr_tdo = cfg_sr[0];
    else if (sel_bsr)   dr_tdo = bsr_sr[0];
  end

  // tdo/tdo_en launch on the falling edge so the host samples them on the next rise.
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo_en <= shift_ir | shift_dr;
      if (shift_ir)      tdo <= ir_sr[0];
      else if (shift_dr) tdo <= dr_tdo;
      else               tdo <= 1'b0;
    end
  end

  assign active        = is_extest | is_intest;
  assign pins_out      = active ? bsr_upd[BSR_W-1:PINS_IN] : logic_pins_out;
  assign logic_pins_in = is_intest ? bsr_upd[PINS_IN-1:0] : pins_in;

endmodule

// File: tb/tb_jtag_tap_gen.sv
// tb/tb_jtag_tap_gen.sv - self-checking bench for jtag_tap_gen
`timescale 1ns/1ps

module tb_jtag_tap_gen;

  localparam int          IR_LEN = 4;
  localparam logic [31:0] IDCODE = 32'h1000_0CAF;
  localparam int S_TLR = 0, S_SHDR = 4, S_SHIR = 11;

  logic        tck = 1'b0, trst = 1'b1, tms = 1'b0, tdi = 1'b0;
  logic        tdo, tdo_en, active, cfg_strobe;
  logic [3:0]  pins_in = 4'h0, pins_out, logic_pins_in, logic_pins_out = 4'h0;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_data, cfg_rdata = 32'h0;

  int checks = 0, errors = 0, strobe_cnt = 0, en_cnt = 0;

  always #5 tck = ~tck;

  jtag_tap_gen #(
    .IR_LEN(IR_LEN), .PINS_IN(4), .PINS_OUT(4), .IDCODE_VAL(IDCODE), .CFG_W(32), .ADDR_W(3)
  ) dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .pins_in(pins_in), .pins_out(pins_out), .logic_pins_in(logic_pins_in),
    .logic_pins_out(logic_pins_out), .active(active), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_strobe(cfg_strobe), .cfg_rdata(cfg_rdata)
  );

  // Reference model: TAP walk from a transition table, each register kept as a bit queue (index 0 = next bit out).
  int nxt_tab [32] = '{1,0, 1,2, 3,9, 4,5, 4,5, 6,8, 6,7, 4,8, 1,2, 10,0, 11,12, 11,12, 13,15, 13,14, 11,15, 1,2};
  int          m_state;
  logic [3:0]  m_ir;
  bit          q_ir[$], q_byp[$], q_id[$], q_bsr[$], q_cfg[$];
  logic [7:0]  m_bsr_upd;
  logic [2:0]  m_addr;
  logic [31:0] m_data;
  logic        m_strobe;

  function automatic int dr_sel(input logic [3:0] op);
    case (op)
      4'd4:             return 1;
      4'd1, 4'd2, 4'd3: return 2;
      4'd5:             return 3;
      default:          return 0;
    endcase
  endfunction

  function automatic void model_clear();
    m_ir = 4'd4;
    q_ir.delete();  for (int i = 0; i < IR_LEN; i++) q_ir.push_back(1'b0);
    q_byp.delete(); q_byp.push_back(1'b0);
    q_id.delete();  for (int i = 0; i < 32; i++) q_id.push_back(1'b0);
    q_bsr.delete(); for (int i = 0; i < 8; i++) q_bsr.push_back(1'b0);
    q_cfg.delete(); for (int i = 0; i < 35; i++) q_cfg.push_back(1'b0);
    m_bsr_upd = '0; m_addr = '0; m_data = '0; m_strobe = 1'b0;
  endfunction

  function automatic bit q_head(input int sel);
    case (sel)
      1:       return q_id[0];
      2:       return q_bsr[0];
      3:       return q_cfg[0];
      default: return q_byp[0];
    endcase
  endfunction

  function automatic void q_shift(input int sel, input bit d);
    case (sel)
      1:       begin void'(q_id.pop_front());  q_id.push_back(d);  end
      2:       begin void'(q_bsr.pop_front()); q_bsr.push_back(d); end
      3:       begin void'(q_cfg.pop_front()); q_cfg.push_back(d); end
      default: begin void'(q_byp.pop_front()); q_byp.push_back(d); end
    endcase
  endfunction

  function automatic void model_rise(input logic tv, input logic dv);
    int s   = m_state;
    int sel = dr_sel(m_ir);
    m_strobe = 1'b0;
    case (s)
      0:  model_clear();
      10: begin
        q_ir.delete(); q_ir.push_back(1'b1);
        for (int i = 1; i < IR_LEN; i++) q_ir.push_back(1'b0);
      end
      11: begin void'(q_ir.pop_front()); q_ir.push_back(dv); end
      15: for (int i = 0; i < IR_LEN; i++) m_ir[i] = q_ir[i];
      3: begin
        if (sel == 0) begin q_byp.delete(); q_byp.push_back(1'b0); end
        else if (sel == 1) begin q_id.delete(); for (int i = 0; i < 32; i++) q_id.push_back(IDCODE[i]); end
        else if (sel == 3) begin
          q_cfg.delete();
          for (int i = 0; i < 32; i++) q_cfg.push_back(cfg_rdata[i]);
          for (int i = 0; i < 3; i++)  q_cfg.push_back(m_addr[i]);
        end else if (m_ir == 4'd3) begin
          for (int i = 0; i < 4; i++) q_bsr[4+i] = logic_pins_out[i];
        end else begin
          q_bsr.delete();
          for (int i = 0; i < 4; i++) q_bsr.push_back(pins_in[i]);
          for (int i = 0; i < 4; i++) q_bsr.push_back(logic_pins_out[i]);
        end
      end
      4: q_shift(sel, dv);
      8: begin
        if (sel == 2) for (int i = 0; i < 8; i++) m_bsr_upd[i] = q_bsr[i];
        if (sel == 3) begin
          for (int i = 0; i < 32; i++) m_data[i] = q_cfg[i];
          for (int i = 0; i < 3; i++)  m_addr[i] = q_cfg[32+i];
          m_strobe = 1'b1;
        end
      end
      default: ;
    endcase
    m_state = nxt_tab[s*2 + int'(tv)];
  endfunction

  function automatic logic exp_active();
    return (m_ir == 4'd1) || (m_ir == 4'd3);
  endfunction

  function automatic logic exp_tdo();
    if (m_state == S_SHIR) return q_ir[0];
    if (m_state == S_SHDR) return q_head(dr_sel(m_ir));
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  // One tck cycle; entered and left just after a falling edge.
  task automatic step(input logic tv, input logic dv);
    tms = tv; tdi = dv;
    @(posedge tck);
    model_rise(tv, dv);
    #1;
    chk("cfg_strobe", cfg_strobe, m_strobe);
    if (cfg_strobe === 1'b1) strobe_cnt++;
    chk("cfg_addr", cfg_addr, m_addr);
    chk("cfg_data", cfg_data, m_data);
    chk("active", active, exp_active());
    chk("pins_out", pins_out, exp_active() ? m_bsr_upd[7:4] : logic_pins_out);
    chk("logic_pins_in", logic_pins_in, (m_ir == 4'd3) ? m_bsr_upd[3:0] : pins_in);
    @(negedge tck);
    #1;
    chk("tdo", tdo, exp_tdo());
    chk("tdo_en", tdo_en, (m_state == S_SHIR) || (m_state == S_SHDR));
    if (tdo_en === 1'b1) en_cnt++;
  endtask

  task automatic do_trst();
    trst = 1'b0;
    m_state = S_TLR;
    model_clear();
    #2;
    chk("rst_tdo", tdo, 0);
    chk("rst_tdo_en", tdo_en, 0);
    chk("rst_active", active, 0);
    chk("rst_strobe", cfg_strobe, 0);
    chk("rst_cfg_addr", cfg_addr, 0);
    chk("rst_cfg_data", cfg_data, 0);
    chk("rst_pins_out", pins_out, logic_pins_out);
    chk("rst_logic_pins_in", logic_pins_in, pins_in);
    trst = 1'b1;
    #1;
  endtask

  task automatic shift_ir(input logic [3:0] code, output logic [3:0] dout);
    dout = '0;
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < IR_LEN; i++) begin
      dout[i] = tdo;
      step(i == IR_LEN - 1, code[i]);
    end
    step(1, 0); step(0, 0);
  endtask

  task automatic shift_dr(input int len, input logic [63:0] din, output logic [63:0] dout);
    dout = '0;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < len; i++) begin
      dout[i] = tdo;
      step(i == len - 1, din[i]);
    end
    step(1, 0); step(0, 0);
  endtask

  typedef struct {
    logic [3:0]  op;
    int          len;
    logic [63:0] din;
    logic [3:0]  pin;
    logic [3:0]  lpo;
    logic [31:0] rdata;
    logic [63:0] dout;
    logic        act;
  } vec_t;

  vec_t tab [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  ir_out;
    logic [63:0] dout, w;

    tab[0] = '{4'd4,  32, 64'h0,           4'b0000, 4'b0000, 32'h0,         64'h1000_0CAF,   1'b0};
    tab[1] = '{4'd0,  1,  64'h1,           4'b0000, 4'b0000, 32'h0,         64'h0,           1'b0};
    tab[2] = '{4'd2,  8,  64'h3C,          4'b1001, 4'b0110, 32'h0,         64'h69,          1'b0};
    tab[3] = '{4'd1,  8,  64'hF0,          4'b0011, 4'b1100, 32'h0,         64'hC3,          1'b1};
    tab[4] = '{4'd3,  8,  64'h00,          4'b1111, 4'b0101, 32'h0,         64'h50,          1'b1};
    tab[5] = '{4'd7,  1,  64'h1,           4'b0000, 4'b0000, 32'h0,         64'h0,           1'b0};
    tab[6] = '{4'd15, 1,  64'h1,           4'b0000, 4'b0000, 32'h0,         64'h0,           1'b0};
    tab[7] = '{4'd6,  1,  64'h0,           4'b0000, 4'b0000, 32'h0,         64'h0,           1'b0};
    tab[8] = '{4'd5,  35, 64'h5_CAFE_F00D, 4'b0000, 4'b0000, 32'hA5A5_0001, 64'h0_A5A5_0001, 1'b0};
    tab[9] = '{4'd5,  35, 64'h0,           4'b0000, 4'b0000, 32'h0F0F_0F0F, 64'h5_0F0F_0F0F, 1'b0};

    // Power-up reset
    #2;
    trst = 1'b0;
    m_state = S_TLR;
    model_clear();
    @(negedge tck); #1;
    chk("por_tdo", tdo, 0);
    chk("por_tdo_en", tdo_en, 0);
    chk("por_active", active, 0);
    chk("por_strobe", cfg_strobe, 0);
    chk("por_cfg_addr", cfg_addr, 0);
    chk("por_cfg_data", cfg_data, 0);
    trst = 1'b1;
    #1;

    // IDCODE straight out of reset, tdo_en only during the 32 shift cycles
    step(0, 0);
    en_cnt = 0;
    shift_dr(32, 64'h0, dout);
    chk("idcode_stream", dout, IDCODE);
    chk("idcode_tdo_en_cycles", en_cnt, 32);

    // Instruction/data vector table
    for (int k = 0; k < 10; k++) begin
      pins_in = tab[k].pin; logic_pins_out = tab[k].lpo; cfg_rdata = tab[k].rdata;
      shift_ir(tab[k].op, ir_out);
      chk("tab_ir_capture", ir_out, 4'b0001);
      chk("tab_active", active, tab[k].act);
      shift_dr(tab[k].len, tab[k].din, dout);
      chk("tab_dr_out", dout, tab[k].dout);
    end

    // BYPASS: tdo is tdi delayed by one cycle, first bit 0
    do_trst();
    step(0, 0);
    shift_ir(4'b0000, ir_out);
    chk("ir_capture", ir_out, 4'b0001);
    w = 64'h0;
    w[8:0] = 9'b101110100;
    shift_dr(9, w, dout);
    chk("bypass_delay", dout, {w[7:0], 1'b0});

    // SAMPLE/PRELOAD then EXTEST
    pins_in = 4'b0100; logic_pins_out = 4'b0101;
    shift_ir(4'd2, ir_out);
    shift_dr(8, 64'hA0, dout);
    chk("sample_capture", dout, 64'h54);
    chk("sample_passthru", pins_out, logic_pins_out);
    shift_ir(4'd1, ir_out);
    chk("extest_pins_out", pins_out, 4'b1010);
    chk("extest_active", active, 1);
    chk("extest_logic_pins_in", logic_pins_in, pins_in);

    // CONFIG write and readback
    shift_ir(4'd5, ir_out);
    strobe_cnt = 0;
    shift_dr(35, 64'h3_DEAD_BEEF, dout);
    chk("cfg_strobe_count", strobe_cnt, 1);
    chk("cfg_addr_written", cfg_addr, 3);
    chk("cfg_data_written", cfg_data, 32'hDEAD_BEEF);
    cfg_rdata = 32'h1234_5678;
    shift_dr(35, 64'h3_DEAD_BEEF, dout);
    chk("cfg_readback", dout, 64'h3_1234_5678);

    // trst in the middle of a CONFIG shift
    strobe_cnt = 0;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 10; i++) step(0, 1);
    do_trst();
    step(1, 0); step(1, 0);
    chk("trst_no_strobe", strobe_cnt, 0);
    chk("trst_cfg_addr", cfg_addr, 0);
    step(0, 0);
    shift_dr(32, 64'h0, dout);
    chk("trst_ir_idcode", dout, IDCODE);

    // Five tms=1 from Shift-IR reach TLR
    shift_ir(4'd1, ir_out);
    chk("pre_tlr_active", active, 1);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("tlr_active", active, 0);
    chk("tlr_pins_out", pins_out, logic_pins_out);
    step(0, 0);
    shift_dr(32, 64'h0, dout);
    chk("tlr_ir_idcode", dout, IDCODE);

    // Pause-DR / Exit2-DR loop inside a CONFIG shift
    shift_ir(4'd5, ir_out);
    w = 64'h6_0BAD_F00D;
    strobe_cnt = 0;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 20; i++) step(i == 19, w[i]);
    step(0, 0); step(0, 0); step(1, 0); step(0, 0);
    chk("pause_no_strobe", strobe_cnt, 0);
    for (int i = 20; i < 35; i++) step(i == 34, w[i]);
    step(1, 0); step(0, 0);
    chk("pause_strobe_count", strobe_cnt, 1);
    chk("pause_cfg_addr", cfg_addr, 6);
    chk("pause_cfg_data", cfg_data, 32'h0BAD_F00D);

    // Randomised walk against the model
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        for (int i = 0; i < 5; i++) step(1, 0);
        step(0, 0);
        shift_ir(4'($urandom_range(0, 7)), ir_out);
      end
      if ($urandom_range(0, 399) == 0) do_trst();
      pins_in        = 4'($urandom);
      logic_pins_out = 4'($urandom);
      cfg_rdata      = $urandom;
      step($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
